// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit holding the architectural HI/LO registers.
// mult/multu/div/divu run for a fixed number of busy cycles and write HI/LO
// on completion; mthi/mtlo write HI/LO directly when the unit is idle.
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu
// (accumulate into {hi,lo}, read at the completion edge).
module ex_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;
`endif

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  // Remaining busy cycles; zero means idle.
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        op_is_mult;
  logic        op_is_div;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [63:0] res;

  assign busy = (cnt_q != 4'd0);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Classify the incoming op; anything not in the enabled set never starts.
  always_comb begin
    op_is_mult = 1'b0;
    op_is_div  = 1'b0;
    case (mdu_op)
      OP_MULT, OP_MULTU: op_is_mult = 1'b1;
      OP_DIV, OP_DIVU:   op_is_div  = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_is_mult = 1'b1;
`endif
      default: ;
    endcase
  end

  // Products: sign/zero extend to 64 bits so the low 64 bits of the
  // product are the exact signed/unsigned result.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide through magnitudes: quotient truncates toward zero,
  // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 without a special case.
  assign a_neg = a_q[31];
  assign b_neg = b_q[31];
  assign a_mag = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag = b_neg ? (32'd0 - b_q) : b_q;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign q_s   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = a_neg ? (32'd0 - r_mag) : r_mag;
  assign q_u   = (b_q == 32'd0) ? 32'd0 : (a_q / b_q);
  assign r_u   = (b_q == 32'd0) ? 32'd0 : (a_q % b_q);

  // Completion value {hi,lo} for the latched op.
  always_comb begin
    res = {hi_q, lo_q};
    case (op_q)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {r_s, q_s};
      OP_DIVU:  res = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {r_u, q_u};
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi_q, lo_q} + prod_s;
      OP_MADDU: res = {hi_q, lo_q} + prod_u;
      OP_MSUB:  res = {hi_q, lo_q} - prod_s;
      OP_MSUBU: res = {hi_q, lo_q} - prod_u;
`endif
      default:  res = {hi_q, lo_q};
    endcase
  end

  // Next-state: start/mthi/mtlo when idle, count down and retire when running.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (cnt_q == 4'd0) begin
      if (start) begin
        if (op_is_mult || op_is_div) begin
          cnt_d = op_is_mult ? MULT_LOAD : DIV_LOAD;
          op_d  = mdu_op;
          a_d   = rs_val;
          b_d   = rt_val;
        end
      end else if (mdu_op == OP_MTHI) begin
        hi_d = rs_val;
      end else if (mdu_op == OP_MTLO) begin
        lo_d = rs_val;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = res[63:32];
        lo_d = res[31:0];
        op_d = OP_NONE;
      end
    end
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
      op_q  <= OP_NONE;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Testbench for ex_mdu: directed vectors, expected {hi,lo} pushed to a
// scoreboard at issue and checked by a monitor when busy falls.
module tb_ex_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests;
  int fails;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];

  ex_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] ok %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: each completion (busy falling not caused by reset) pops one entry.
  logic busy_prev;
  logic rst_prev;
  initial begin
    busy_prev = 1'b0;
    rst_prev  = 1'b1;
    forever begin
      @(negedge clk);
      if (busy_prev && !busy && !rst_prev) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_completion: hi=0x%08h lo=0x%08h expected no completion", hi, lo);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_hi"}, hi, e.val[63:32]);
          check({e.name, "_lo"}, lo, e.val[31:0]);
        end
      end
      busy_prev = busy;
      rst_prev  = reset;
    end
  end

  // Issue one op, count busy cycles, optionally disturb with a start and an
  // mthi while busy (both must be ignored).
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int cycles,
                        input bit disturb);
    exp_t e;
    int n;
    @(posedge clk); #1;
    start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    e.name = name; e.val = exp;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (disturb) begin
        if (n == 2) begin
          start = 1'b1; mdu_op = 4'd3; rs_val = 32'd100; rt_val = 32'd3;
        end else if (n == 3) begin
          start = 1'b0; mdu_op = 4'd5; rs_val = 32'h1234_5678;
        end else if (n == 4) begin
          mdu_op = 4'd0;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0; mdu_op = 4'd0;
    check({name, "_busy_cycles"}, 32'(n), 32'(cycles));
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    mdu_op = op; rs_val = a;
    @(posedge clk); #1;
    mdu_op = 4'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [31:0] hi_s;
    tests = 0; fails = 0;
    reset = 1'b1; start = 1'b0; mdu_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    run_op("mult_m2x3", 4'd1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5, 1'b0);
    run_op("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 1'b0);
    run_op("mult_minsq", 4'd1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 5, 1'b0);
    run_op("div_m7d2", 4'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10, 1'b0);
    run_op("div_7dm2", 4'd3, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 10, 1'b0);
    run_op("divu_7d0", 4'd4, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, 10, 1'b0);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10, 1'b0);
    run_op("div_m9d0", 4'd3, 32'hFFFF_FFF7, 32'd0, 64'hFFFF_FFF7_FFFF_FFFF, 10, 1'b0);
    run_op("divu_100d7", 4'd4, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 10, 1'b0);
    run_op("mult_disturbed", 4'd1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 5, 1'b1);

    // mtlo after completion: lo written at next edge, hi kept.
    move_to(4'd6, 32'hCAFE_BABE);
    check("mtlo_lo", lo, 32'hCAFE_BABE);
    check("mtlo_hi_kept", hi, 32'h0000_0001);
    move_to(4'd5, 32'hDEAD_BEEF);
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_lo_kept", lo, 32'hCAFE_BABE);

    // Reset on the 4th busy cycle of a div aborts it.
    @(posedge clk); #1;
    start = 1'b1; mdu_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    nb = 0;
    repeat (15) begin @(posedge clk); #1; if (busy) nb++; end
    check("abort_no_busy", 32'(nb), 32'd0);
    check("abort_hi_late", hi, 32'd0);
    check("abort_lo_late", lo, 32'd0);

    // madd-class op: accumulates when enabled, ignored otherwise.
    move_to(4'd6, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("madd_carry", 4'd8, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 5, 1'b0);
    run_op("msubu_back", 4'd11, 32'd1, 32'd1, 64'h0000_0000_FFFF_FFFF, 5, 1'b0);
`else
    hi_s = hi;
    @(posedge clk); #1;
    start = 1'b1; mdu_op = 4'd8; rs_val = 32'd1; rt_val = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
    nb = 0;
    repeat (8) begin if (busy) nb++; @(posedge clk); #1; end
    check("madd_off_busy", 32'(nb), 32'd0);
    check("madd_off_hi", hi, hi_s);
    check("madd_off_lo", lo, 32'hFFFF_FFFF);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
